// File: rtl/rv_core_pkg.sv
// ============================================================================
// Module      : rv_core_pkg
// Description : Shared core types and constants for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_core_pkg;

    localparam int              XLEN         = 32;
    localparam logic [XLEN-1:0] NOP_ENC      = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_DROP = 3'd3,
        S_TRAP = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } fetch_slot_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Instruction-memory request/response bus of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
    import rv_core_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/if_skid_buf.sv
// ============================================================================
// Module      : if_skid_buf
// Description : One-entry {pc,pc4,instr} buffer; clear beats load beats unload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_skid_buf
    import rv_core_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_load,
    input  wire logic        i_unload,
    input  wire logic        i_clear,
    input  wire fetch_slot_t i_data,
    output fetch_slot_t      o_data,
    output logic             o_full
);

    fetch_slot_t r_data;
    logic        r_full;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module      : if_fetch_unit
// Description : IF stage: owns fetch PC, single-outstanding imem requests,
//               one-entry skid, EX redirects and hazard stalls.
//               Optional macro FETCH_MISALIGN_TRAP_EN enables misaligned-target trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
)(
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            stall,
    input  wire logic            redirect_valid,
    input  wire logic [XLEN-1:0] redirect_pc,
    if_fetch_unit_if.master      imem,
    output logic [XLEN-1:0]      pc_out,
    output logic [XLEN-1:0]      pc4_out,
    output logic [XLEN-1:0]      instr_out,
    output logic                 valid_out,
    output logic                 fetch_misalign
);

    fetch_state_e    r_state, w_state_n;
    logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_n;
    fetch_slot_t     r_slot, w_slot_n;
    logic            r_valid, w_valid_n;
    logic            r_misalign, w_misalign_n;
    logic            r_trap_pend, w_trap_pend_n;

    logic            w_free, w_consume, w_in_flight;
    logic            w_skid_load, w_skid_unload, w_skid_clear, w_skid_full;
    fetch_slot_t     w_resp, w_skid_q;
    logic [XLEN-1:0] w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_target = redirect_pc;
`else
    assign w_target = {redirect_pc[XLEN-1:2], 2'b00};
    logic  w_unused_pc_lsb;
    assign w_unused_pc_lsb = &{1'b0, redirect_pc[1:0]};
`endif

    assign w_free    = !r_valid || !stall;
    assign w_consume = r_valid && !stall && !r_misalign;
    assign w_resp    = '{pc: r_fetch_pc, pc4: pc_plus4(r_fetch_pc), instr: imem.imem_rdata};
    // A response arriving in the redirect cycle is already spent, so it leaves nothing in flight.
    assign w_in_flight = (((r_state == S_WAIT) || (r_state == S_DROP)) && !imem.imem_rvalid)
                       || ((r_state == S_REQ) && imem.imem_gnt);

    always_comb begin
        w_state_n     = r_state;
        w_fetch_pc_n  = r_fetch_pc;
        w_slot_n      = r_slot;
        w_valid_n     = r_valid;
        w_misalign_n  = r_misalign;
        w_trap_pend_n = r_trap_pend;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_skid_clear  = 1'b0;

        if (w_consume) begin
            w_valid_n      = 1'b0;
            w_slot_n.instr = NOP_INSTR;
        end

        if (redirect_valid) begin
            w_skid_clear  = 1'b1;
            w_fetch_pc_n  = w_target;
            w_slot_n      = '{pc: '0, pc4: '0, instr: NOP_INSTR};
            w_valid_n     = 1'b0;
            w_misalign_n  = 1'b0;
            w_trap_pend_n = 1'b0;
            w_state_n     = w_in_flight ? S_DROP : S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_target[1:0] != 2'b00) begin
                w_slot_n      = '{pc: redirect_pc, pc4: pc_plus4(redirect_pc), instr: NOP_INSTR};
                w_valid_n     = 1'b1;
                w_misalign_n  = 1'b1;
                w_trap_pend_n = w_in_flight;
                w_state_n     = w_in_flight ? S_DROP : S_TRAP;
            end
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem.imem_gnt) w_state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        w_fetch_pc_n = pc_plus4(r_fetch_pc);
                        if (w_free) begin
                            w_slot_n  = w_resp;
                            w_valid_n = 1'b1;
                            w_state_n = S_REQ;
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_n   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_slot_n      = w_skid_q;
                        w_valid_n     = 1'b1;
                        w_skid_unload = 1'b1;
                        w_state_n     = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem.imem_rvalid) begin
                        w_state_n     = r_trap_pend ? S_TRAP : S_REQ;
                        w_trap_pend_n = 1'b0;
                    end
                end
                S_TRAP:  w_state_n = S_TRAP;
                default: w_state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_fetch_pc  <= RESET_PC;
            r_slot      <= '{pc: '0, pc4: '0, instr: NOP_INSTR};
            r_valid     <= 1'b0;
            r_misalign  <= 1'b0;
            r_trap_pend <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_fetch_pc  <= w_fetch_pc_n;
            r_slot      <= w_slot_n;
            r_valid     <= w_valid_n;
            r_misalign  <= w_misalign_n;
            r_trap_pend <= w_trap_pend_n;
        end
    end

    if_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_skid_clear),
        .i_data   (w_resp),
        .o_data   (w_skid_q),
        .o_full   (w_skid_full)
    );

    assign imem.imem_req  = (r_state == S_REQ);
    assign imem.imem_addr = r_fetch_pc;
    assign pc_out         = r_slot.pc;
    assign pc4_out        = r_slot.pc4;
    assign instr_out      = r_slot.instr;
    assign valid_out      = r_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = r_misalign;
`else
    assign fetch_misalign = 1'b0;
`endif

    a_rvalid_protocol: assert property (@(posedge clk) disable iff (reset)
        imem.imem_rvalid |-> ((r_state != S_REQ) && (r_state != S_HOLD)));
    a_hold_has_skid: assert property (@(posedge clk) disable iff (reset)
        (r_state == S_HOLD) |-> w_skid_full);

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed bench for if_fetch_unit with an imem model and an
//               in-order program-flow scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;
    import rv_core_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_out, pc4_out, instr_out;
    logic        valid_out, fetch_misalign;

    int vectors = 0;
    int miscompares = 0;

    // imem model state
    logic        gnt_en = 1'b1;
    logic        poison = 1'b0;
    int          lat = 1;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    logic [31:0] gnt_log[$];
    logic [31:0] exp_pc;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .pc_out         (pc_out),
        .pc4_out        (pc4_out),
        .instr_out      (instr_out),
        .valid_out      (valid_out),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign bus.imem_gnt    = gnt_en & bus.imem_req;
    assign bus.imem_rvalid = pend && (cnt == 0);
    assign bus.imem_rdata  = poison ? 32'hDEAD_BEEF : memf(paddr);

    always @(posedge clk) begin
        if (reset) begin
            pend  <= 1'b0;
            cnt   <= 0;
            paddr <= 32'h0;
        end else if (bus.imem_gnt) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= bus.imem_addr;
            gnt_log.push_back(bus.imem_addr);
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program-flow model: consumed slots must walk the address stream from the last redirect target.
    always @(negedge clk) begin
        if (reset) begin
            exp_pc = 32'h0;
        end else begin
            if (valid_out && !stall && !redirect_valid && !fetch_misalign) begin
                chk("flow_pc", pc_out, exp_pc);
                chk("flow_pc4", pc4_out, exp_pc + 32'd4);
                chk("flow_instr", instr_out, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (!valid_out) chk("bubble_nop", instr_out, NOP);
            if (bus.imem_req) begin
                chk("one_outstanding", {31'b0, pend}, 32'h0);
                chk("addr_aligned", {30'b0, bus.imem_addr[1:0]}, 32'h0);
            end
`ifndef FETCH_MISALIGN_TRAP_EN
            chk("misalign_tied", {31'b0, fetch_misalign}, 32'h0);
`endif
            if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                exp_pc = redirect_pc;
`else
                exp_pc = redirect_pc & ~32'h3;
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pc4", pc4_out, 32'h0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_valid", {31'b0, valid_out}, 32'h0);
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'h1);
        chk("rst_addr", bus.imem_addr, 32'h0);
        reset = 1'b0;

        // Streaming fetch, 2 cycles per instruction
        cyc();
        chk("t1_wait_noreq", {31'b0, bus.imem_req}, 32'h0);
        cyc();
        chk("t1_pc0", pc_out, 32'h0);
        chk("t1_instr0", instr_out, 32'hA5A5_5A5A);
        chk("t1_valid_hi", {31'b0, valid_out}, 32'h1);
        chk("t1_addr4", bus.imem_addr, 32'h4);
        cyc();
        chk("t1_valid_lo", {31'b0, valid_out}, 32'h0);
        cyc();
        chk("t1_pc4", pc_out, 32'h4);
        chk("t1_pc4_4", pc4_out, 32'h8);
        cyc();
        cyc();
        chk("t1_pc8", pc_out, 32'h8);
        chk("t1_ngnt", gnt_log.size(), 32'd3);
        if (gnt_log.size() >= 3) begin
            chk("t1_gnt0", gnt_log[0], 32'h0);
            chk("t1_gnt1", gnt_log[1], 32'h4);
            chk("t1_gnt2", gnt_log[2], 32'h8);
        end

        // Response into a full, stalled slot goes to the skid
        stall = 1'b1;
        cyc();
        cyc();
        chk("t2_hold_noreq", {31'b0, bus.imem_req}, 32'h0);
        chk("t2_hold_pc", pc_out, 32'h8);
        cyc();
        chk("t2_hold_noreq2", {31'b0, bus.imem_req}, 32'h0);
        stall = 1'b0;
        cyc();
        chk("t2_skid_pc", pc_out, 32'hC);
        chk("t2_skid_instr", instr_out, 32'hA5A5_5A56);
        chk("t2_next_addr", bus.imem_addr, 32'h10);
        chk("t2_req", {31'b0, bus.imem_req}, 32'h1);
        lat = 2;

        // Redirect while waiting: poisoned response must vanish
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        poison = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        chk("t3_valid", {31'b0, valid_out}, 32'h0);
        chk("t3_nop", instr_out, NOP);
        chk("t3_drop_noreq", {31'b0, bus.imem_req}, 32'h0);
        cyc();
        chk("t3_addr", bus.imem_addr, 32'h100);
        chk("t3_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t3_valid2", {31'b0, valid_out}, 32'h0);
        poison = 1'b0;
        lat = 1;
        cyc();
        cyc();
        chk("t3_pc", pc_out, 32'h100);
        chk("t3_instr", instr_out, 32'hA5A5_5B5A);

        // Redirect beats rvalid and stall in the same cycle
        stall = 1'b1;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        stall = 1'b0;
        chk("t4_valid", {31'b0, valid_out}, 32'h0);
        chk("t4_pc", pc_out, 32'h0);
        chk("t4_pc4", pc4_out, 32'h0);
        chk("t4_nop", instr_out, NOP);
        chk("t4_addr", bus.imem_addr, 32'h200);
        chk("t4_req", {31'b0, bus.imem_req}, 32'h1);
        cyc();
        cyc();
        chk("t4_pc200", pc_out, 32'h200);
        chk("t4_instr200", instr_out, 32'hA5A5_585A);

        // Wrap at top of address space (redirect while granted -> drop)
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        chk("t5_drop_noreq", {31'b0, bus.imem_req}, 32'h0);
        cyc();
        chk("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cyc();
        cyc();
        chk("t5_pc", pc_out, 32'hFFFF_FFFC);
        chk("t5_pc4_wrap", pc4_out, 32'h0);
        chk("t5_instr", instr_out, 32'h5A5A_A5A6);
        chk("t5_next_addr", bus.imem_addr, 32'h0);
        gnt_en = 1'b0;
        cyc();
        chk("t5_addr_stable", bus.imem_addr, 32'h0);
        chk("t5_req_stable", {31'b0, bus.imem_req}, 32'h1);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned target traps after draining the outstanding request
        gnt_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        cyc();
        redirect_valid = 1'b0;
        chk("t6_misalign", {31'b0, fetch_misalign}, 32'h1);
        chk("t6_pc", pc_out, 32'h102);
        chk("t6_pc4", pc4_out, 32'h106);
        chk("t6_valid", {31'b0, valid_out}, 32'h1);
        cyc();
        cyc();
        chk("t6_trap_noreq", {31'b0, bus.imem_req}, 32'h0);
        chk("t6_trap_held", pc_out, 32'h102);
        chk("t6_trap_valid", {31'b0, valid_out}, 32'h1);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        chk("t6_clear", {31'b0, fetch_misalign}, 32'h0);
        chk("t6_valid_lo", {31'b0, valid_out}, 32'h0);
        chk("t6_resume", bus.imem_addr, 32'h200);
        chk("t6_req", {31'b0, bus.imem_req}, 32'h1);
        cyc();
        cyc();
        chk("t6_pc200", pc_out, 32'h200);
        chk("t6_instr200", instr_out, 32'hA5A5_585A);
`else
        // Misaligned target is silently aligned; redirect in S_REQ without grant
        redirect_valid = 1'b1;
        redirect_pc = 32'h302;
        cyc();
        redirect_valid = 1'b0;
        chk("t7_aligned", bus.imem_addr, 32'h300);
        chk("t7_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t7_misalign", {31'b0, fetch_misalign}, 32'h0);
        gnt_en = 1'b1;
        cyc();
        cyc();
        chk("t7_pc", pc_out, 32'h300);
        chk("t7_instr", instr_out, 32'hA5A5_595A);
`endif

        repeat (4) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
